// File: rtl/seq_pkg.sv
// Shared types and state constants for the sequence-detector family.
// The detectors reuse the ST_* encodings below.
package seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } ser_state_t;

  function automatic int tick_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_tick.sv
// Bit-period timer: bit_end pulses on the last clock of each bit.
// A clear strobe restarts the period at its first clock.
module seq_bit_tick
  import seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int TW = tick_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_cnt;

  assign bit_end = (tick_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clear || bit_end) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bitstream serializer with back-to-back frame support.
// Define SEQ_SER_PARITY_EN to append an even-parity bit per frame.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             bit_end;
  logic             last_period;
  logic             accept;
  logic             head;

  seq_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bit_end(bit_end)
  );

  assign head = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

`ifdef SEQ_SER_PARITY_EN
  logic par;

  assign last_period = (state == PARITY);
  assign ser_out     = (state == SHIFT)  ? head :
                       (state == PARITY) ? par  : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^in_data;
    end
  end
`else
  assign last_period = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign ser_out     = (state == SHIFT) && head;
`endif

  // Ready looks ahead to the final clock so frames can abut.
  assign in_ready    = (state == IDLE) || (last_period && bit_end);
  assign accept      = in_valid && in_ready;
  assign ser_valid   = (state != IDLE);
  assign frame_start = (state == SHIFT) && (bit_cnt == '0);
  assign frame_end   = last_period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= in_data;
      bit_cnt <= '0;
    end else if (bit_end) begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef SEQ_SER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            if (MSB_FIRST != 0) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
